// File: rtl/xbar_lane_framer.sv
// Crossbar lane framer: prepends a dest/VLAN/source header beat, enforces max body length.
// Drop/truncation counters are present only when XBAR_LANE_FRAMER_STATS_EN is defined.
module xbar_lane_framer #(
  parameter logic [5:0] XBAR_PORT      = 6'd0,
  parameter int         NUM_XBAR_PORTS = 50,
  parameter int         MAX_BEATS      = 190
) (
  input  logic        clk_fabric,
  input  logic        areset_n,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tlast,
  input  logic [6:0]  s_tdest,
  input  logic [11:0] s_tuser,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] drop_count,
  output logic [15:0] trunc_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_BODY,
    S_DRAIN
  } state_t;

  localparam logic [7:0] NPORTS   = 8'(NUM_XBAR_PORTS);
  localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

  state_t      state_q, state_d;
  logic [6:0]  dest_q, dest_d;
  logic [11:0] vlan_q, vlan_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        dest_ok;
  logic        at_max;
  logic [63:0] hdr;

  assign dest_ok = (s_tdest == 7'h7F) ||
                   ({1'b0, s_tdest} < NPORTS);
  assign at_max  = (beat_cnt_q == LAST_IDX);
  assign hdr     = {8'h5A, dest_q, 5'd0, vlan_q,
                    XBAR_PORT, 26'd0};

  always_ff @(posedge clk_fabric or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      dest_q     <= '0;
      vlan_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      vlan_q     <= vlan_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    vlan_d     = vlan_q;
    beat_cnt_d = beat_cnt_q;
    s_tready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tkeep    = '0;
    m_tlast    = 1'b0;
    m_tuser    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (s_tvalid) begin
          dest_d  = s_tdest;
          vlan_d  = s_tuser;
          state_d = dest_ok ? S_HEADER : S_DRAIN;
        end
      end
      S_HEADER: begin
        m_tvalid = 1'b1;
        m_tkeep  = 8'hFF;
        m_tdata  = hdr;
        if (m_tready) begin
          state_d    = S_BODY;
          beat_cnt_d = '0;
        end
      end
      S_BODY: begin
        // zero-latency pass-through; the length cap forces tlast
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tlast  = s_tlast | at_max;
        m_tuser  = at_max & ~s_tlast;
        if (s_tvalid && m_tready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (s_tlast)
            state_d = S_IDLE;
          else if (at_max)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef XBAR_LANE_FRAMER_STATS_EN
  logic        drop_evt;
  logic        trunc_evt;
  logic [15:0] drop_q;
  logic [15:0] trunc_q;

  assign drop_evt  = (state_q == S_IDLE) && s_tvalid &&
                     !dest_ok;
  assign trunc_evt = (state_q == S_BODY) && s_tvalid &&
                     m_tready && !s_tlast && at_max;

  always_ff @(posedge clk_fabric or negedge areset_n) begin
    if (!areset_n) begin
      drop_q  <= '0;
      trunc_q <= '0;
    end else begin
      if (drop_evt && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;
      if (trunc_evt && (trunc_q != 16'hFFFF))
        trunc_q <= trunc_q + 16'd1;
    end
  end

  assign drop_count  = drop_q;
  assign trunc_count = trunc_q;
`else
  assign drop_count  = 16'h0;
  assign trunc_count = 16'h0;
`endif

endmodule

// File: tb/tb_xbar_lane_framer.sv
// Bench for xbar_lane_framer: packet-level model plus directed vectors.
// Runs with MAX_BEATS=8 so exact-length and truncated frames stay short.
module tb_xbar_lane_framer;

  localparam int         MAXB   = 8;
  localparam int         NPORTS = 50;
  localparam logic [5:0] XP     = 6'd0;
`ifdef XBAR_LANE_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [6:0]  s_tdest;
  logic [11:0] s_tuser;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [15:0] drop_count, trunc_count;

  int vectors = 0;
  int errors  = 0;
  int exp_drop = 0;
  int exp_trunc = 0;
  int ready_mode = 0;
  int pkt_id = 0;
  int base;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [63:0] pd[16];
  logic [7:0]  pk[16];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [63:0] d0;

  always #5 clk = ~clk;

  xbar_lane_framer #(
    .XBAR_PORT(XP),
    .NUM_XBAR_PORTS(NPORTS),
    .MAX_BEATS(MAXB)
  ) dut (
    .clk_fabric(clk),
    .areset_n(rst_n),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tkeep(s_tkeep),
    .s_tlast(s_tlast),
    .s_tdest(s_tdest),
    .s_tuser(s_tuser),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tkeep(m_tkeep),
    .m_tlast(m_tlast),
    .m_tuser(m_tuser),
    .drop_count(drop_count),
    .trunc_count(trunc_count)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic beat_t got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return '0;
  endfunction

  function automatic logic [63:0] hdr(input logic [6:0] dest,
                                      input logic [11:0] vlan);
    return (64'h5A << 56) | (64'(dest) << 49) |
           (64'(vlan) << 32) | (64'(XP) << 26);
  endfunction

  // Expected output for one whole input packet held in pd/pk
  task automatic model_pkt(input logic [6:0] dest,
                           input logic [11:0] vlan,
                           input int n);
    int m;
    if (!(dest == 7'h7F || int'(dest) < NPORTS)) begin
      if (exp_drop < 65535) exp_drop++;
      return;
    end
    m = (n > MAXB) ? MAXB : n;
    exp_q.push_back('{hdr(dest, vlan), 8'hFF, 1'b0, 1'b0});
    for (int i = 0; i < m; i++)
      exp_q.push_back('{pd[i], pk[i], (i == m - 1),
                        (i == m - 1) && (n > MAXB)});
    if (n > MAXB && exp_trunc < 65535) exp_trunc++;
  endtask

  task automatic send_pkt(input logic [6:0] dest,
                          input logic [11:0] vlan,
                          input int n,
                          input logic [7:0] last_keep,
                          input bit gaps);
    bit acc;
    pkt_id++;
    for (int i = 0; i < n; i++) begin
      pd[i] = {8'(pkt_id), 8'(i), 16'hC0DE, $urandom};
      pk[i] = (i == n - 1) ? last_keep : 8'hFF;
    end
    model_pkt(dest, vlan, n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      s_tvalid = 1'b1;
      s_tdata  = pd[i];
      s_tkeep  = pk[i];
      s_tlast  = (i == n - 1);
      s_tdest  = (i == 0) ? dest : 7'($urandom);
      s_tuser  = (i == 0) ? vlan : 12'($urandom);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        vectors++;
        errors++;
        $display("FAIL accept_timeout pkt %0d beat %0d: got no s_tready want 1",
                 pkt_id, i);
        s_tvalid = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_drop"}, 64'(drop_count),
          STATS ? 64'(exp_drop) : 64'd0);
    check({tag, "_trunc"}, 64'(trunc_count),
          STATS ? 64'(exp_trunc) : 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) m_tready = 1'b1;
      else if (ready_mode == 1) m_tready = 1'($urandom_range(0, 1));
    end
  end

  // Every accepted output beat is scored against the model queue
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(m_tvalid), 64'd1);
        check("stall_hold_data", m_tdata, prev_data);
      end
      if (m_tvalid && m_tready) begin
        got_q.push_back('{m_tdata, m_tkeep, m_tlast, m_tuser});
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_beat: got %h want none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_keep", 64'(m_tkeep), 64'(e.keep));
          check("out_last", 64'(m_tlast), 64'(e.last));
          if (e.last)
            check("out_user", 64'(m_tuser), 64'(e.user));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tdest  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tuser", 64'(m_tuser), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_trunc", 64'(trunc_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // dest 3, VLAN 69, exactly MAXB beats: normal end
    base = got_q.size();
    send_pkt(7'd3, 12'd69, 8, 8'hFF, 1'b0);
    @(posedge clk); #1;
    check("p1_beats", 64'(got_q.size() - base), 64'd9);
    check("p1_header", got_at(base).data, 64'h5A06_0045_0000_0000);
    check("p1_last", 64'(got_at(base + 8).last), 64'd1);
    check("p1_user", 64'(got_at(base + 8).user), 64'd0);

    // flood, single beat with partial keep
    base = got_q.size();
    send_pkt(7'h7F, 12'd0, 1, 8'h0F, 1'b0);
    @(posedge clk); #1;
    check("p2_beats", 64'(got_q.size() - base), 64'd2);
    check("p2_header", got_at(base).data, 64'h5AFE_0000_0000_0000);
    check("p2_keep", 64'(got_at(base + 1).keep), 64'h0F);
    check("p2_last", 64'(got_at(base + 1).last), 64'd1);

    // illegal dests 60 and 50 are drained, legal 49 framed
    base = got_q.size();
    send_pkt(7'd60, 12'd1, 5, 8'hFF, 1'b0);
    @(posedge clk); #1;
    check("p3_no_output", 64'(got_q.size() - base), 64'd0);
    check_counters("p3");
    send_pkt(7'd50, 12'd2, 2, 8'hFF, 1'b0);
    @(posedge clk); #1;
    check("p4_no_output", 64'(got_q.size() - base), 64'd0);
    base = got_q.size();
    send_pkt(7'd49, 12'hFFF, 3, 8'h01, 1'b0);
    @(posedge clk); #1;
    check("p5_header", got_at(base).data, 64'h5A62_0FFF_0000_0000);
    check_counters("p5");

    // 10-beat packet truncated at MAXB, then a normal one
    base = got_q.size();
    send_pkt(7'd2, 12'd7, 10, 8'hFF, 1'b0);
    @(posedge clk); #1;
    check("p6_beats", 64'(got_q.size() - base), 64'd9);
    check("p6_last", 64'(got_at(base + 8).last), 64'd1);
    check("p6_user", 64'(got_at(base + 8).user), 64'd1);
    check_counters("p6");
    base = got_q.size();
    send_pkt(7'd4, 12'd8, 2, 8'h3F, 1'b0);
    @(posedge clk); #1;
    check("p7_beats", 64'(got_q.size() - base), 64'd3);
    check("p7_user", 64'(got_at(base + 2).user), 64'd0);

    // random downstream stalls and upstream gaps, back to back
    ready_mode = 1;
    send_pkt(7'd10, 12'h0AB, 5, 8'h7F, 1'b1);
    send_pkt(7'd20, 12'h0CD, 1, 8'h03, 1'b1);
    send_pkt(7'h7F, 12'h0EF, 7, 8'hFF, 1'b1);
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_counters("rand");

    // reset while a body beat is stalled
    ready_mode = 2;
    m_tready   = 1'b0;
    d0         = 64'hDEAD_BEEF_0000_0001;
    s_tvalid   = 1'b1;
    s_tdata    = d0;
    s_tkeep    = 8'hFF;
    s_tlast    = 1'b0;
    s_tdest    = 7'd5;
    s_tuser    = 12'h123;
    exp_q.push_back('{hdr(7'd5, 12'h123), 8'hFF, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("rs_hdr_valid", 64'(m_tvalid), 64'd1);
    check("rs_hdr_data", m_tdata, 64'h5A0A_0123_0000_0000);
    check("rs_hdr_sready", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    @(negedge clk);
    check("rs_body_valid", 64'(m_tvalid), 64'd1);
    check("rs_body_data", m_tdata, d0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rs_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rs_s_tready", 64'(s_tready), 64'd0);
    exp_q.delete();
    exp_drop  = 0;
    exp_trunc = 0;
    s_tvalid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    ready_mode = 0;
    m_tready   = 1'b1;
    check_counters("rs_after");
    base = got_q.size();
    send_pkt(7'd9, 12'h456, 2, 8'hFF, 1'b0);
    @(posedge clk); #1;
    check("rs_next_beats", 64'(got_q.size() - base), 64'd3);
    check("rs_next_header", got_at(base).data, 64'h5A12_0456_0000_0000);

    repeat (2) @(posedge clk);
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
